// File: rtl/imem_loader.sv
// Boot loader for the core's instruction memory: receives a framed byte
// stream (magic, 16-bit word count, little-endian words), writes the words
// sequentially into the instruction memory and releases the core when complete.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              core_pc_enable,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CAP   = 1 << ADDR_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] CNT_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              take;
  logic [7:0]        n_lo;
  logic [31:0]       count_full;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] n_last;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;

  // Handshake: the loader only listens while parsing the header or data bytes.
  always_comb begin
    byte_ready = 1'b0;
    if (state == IDLE || state == CNT_LO || state == CNT_HI || state == DATA)
      byte_ready = 1'b1;
    take       = byte_valid & byte_ready;
    count_full = {16'd0, byte_in, n_lo};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; DONE and ERROR are terminal until reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (take && byte_in == MAGIC) state_next = CNT_LO;
      CNT_LO: if (take) state_next = CNT_HI;
      CNT_HI: begin
        if (take) begin
          if (count_full > CAP)           state_next = ERROR;
          else if (count_full == 32'd0)   state_next = DONE;
          else                            state_next = DATA;
        end
      end
      DATA:   if (take && byte_idx == 2'd3) state_next = WRITE;
      WRITE:  state_next = (word_idx == n_last) ? DONE : DATA;
      default: state_next = state;
    endcase
  end

  // Datapath: header capture, word assembly, write strobe and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lo           <= 8'd0;
      n_last         <= '0;
      word_idx       <= '0;
      byte_idx       <= 2'd0;
      word_buf       <= 24'd0;
      imem_we        <= 1'b0;
      imem_waddr     <= '0;
      imem_wdata     <= 32'd0;
      words_loaded   <= '0;
      core_reset     <= 1'b1;
      core_pc_enable <= 1'b0;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        CNT_LO: if (take) n_lo <= byte_in;
        CNT_HI: begin
          if (take) begin
            n_last   <= ADDR_W'(count_full - 32'd1);
            word_idx <= '0;
            byte_idx <= 2'd0;
          end
        end
        DATA: begin
          if (take) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_in;
              2'd1: word_buf[15:8]  <= byte_in;
              2'd2: word_buf[23:16] <= byte_in;
              default: begin
                // Last lane bypasses the buffer so the write lands next cycle.
                imem_we    <= 1'b1;
                imem_waddr <= word_idx;
                imem_wdata <= {byte_in, word_buf};
              end
            endcase
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + CNT_W'(1);
          if (word_idx != n_last) word_idx <= word_idx + ADDR_W'(1);
        end
        default: ;
      endcase
      core_reset     <= (state_next != DONE);
      core_pc_enable <= (state_next == DONE);
      load_done      <= (state_next == DONE);
      load_error     <= (state_next == ERROR);
    end
  end

endmodule
